rpn_stack_eval: RTL and testbench
=================================

# rpn_stack_eval

Stack-based expression evaluator downstream of the calculator state machine. It consumes the token stream (operands and operators) that the state machine emits after digit assembly. Evaluation is infix with precedence, using a two-stack shunting-yard scheme. The 32-bit result and done/error status go back to the state machine and to the display/VGA buffer path.

## Interface
- DEPTH, 8: entries in each of the operand and operator stacks (power of two, ≥2)
- W, 32: data width
- clk  in  1  system clock (50 MHz domain)
- reset_n  in  1  synchronous, active-low reset
- clear  in  1  synchronous soft clear: empties both stacks, returns to IDLE (same effect as reset)
- strobe  in  1  token valid; accepted only in a cycle where ready=1
- is_op  in  1  1: token[3:0] is an operator code; 0: token is a W-bit operand
- token  in  W  operand value or operator code (4'hA add, 4'hB sub, 4'hC mul, 4'hE equals)
- ready  out  1  block can accept a token this cycle
- answer  out  W  result, valid while done=1
- done  out  1  evaluation complete; held until clear/reset
- error  out  1  evaluation failed; held until clear/reset

## Operation
- States: IDLE, REDUCE, FINISH, DONE, ERROR.
- IDLE (ready=1):
  - Operand: push onto operand stack.
  - Operator with top-of-op-stack precedence ≥ new precedence: latch the pending op, go to REDUCE.
  - Otherwise: push the op.
  - Equals: go to FINISH.
- Precedence: mul=2, add/sub=1. Equal-precedence ops reduce first, giving left associativity.
- REDUCE (ready=0), one reduction per cycle:
  - Pop op, pop b (top), pop a; push a op b.
  - Repeat while the top op still has precedence ≥ the pending op.
  - Then push the pending op and return to IDLE.
- FINISH (ready=0): reduce one op per cycle until the op stack is empty.
  - Operand count must then be exactly 1: answer = that value, go to DONE.
  - Any other count: go to ERROR.
- Arithmetic: two's complement, wraps modulo 2^W. mul keeps the low W bits of the product. No saturation or overflow flag.
- Error conditions (go to ERROR, answer=0):
  - push to a full stack (either stack)
  - reduce with fewer than 2 operands
  - operator code not in {A,B,C,E}
- DONE and ERROR: ready=0, strobes ignored, outputs held.
- clear and reset_n both take effect in any state, including mid-REDUCE. reset_n has priority over clear.

## Timing
- Reset/clear values: ready=1, answer=0, done=0, error=0, both stack pointers=0, state=IDLE.
- Operand or non-reducing operator: accepted in the strobe cycle; ready stays 1, so back-to-back tokens are allowed every cycle.
- Reducing operator: ready=0 for k+1 cycles, where k = number of reductions. The last cycle pushes the pending op.
- Equals with n stacked ops: done (or error) is asserted n+1 cycles after the strobe edge, registered.
- All outputs are registered. The stacks are synchronous-write registers with no combinational path from strobe to ready.
- strobe while ready=0 is ignored; the upstream must hold the token until it sees ready=1.

## Structure
- Shared package calc_pkg holds:
  - operator code constants OP_ADD/OP_SUB/OP_MUL/OP_EQ
  - the prec() function
  - the state enum
- These constants are shared with the state machine and the VGA buffer.
- One sub-module, calc_stack (parameters W, DEPTH):
  - ports: push, pop, data_in, top, count, full, empty
  - simultaneous push+pop replaces top
- calc_stack is instantiated twice: operand stack W=32, operator stack W=4.

## Test plan
- 2 + 3 * 4 = → ready never drops before equals; done after 3 cycles; answer=14.
- 2 * 3 + 4 = → ready low 2 cycles after '+'; answer=10.
- 7 - 2 - 1 = → answer=4 (left associativity).
- 32'hFFFFFFFF + 1 = → answer=0. 32'h10000 * 32'h10000 = → answer=0, error=0.
- 9 operands with DEPTH=8 → error=1 on the 9th push, answer=0; "3 + =" → error=1.
- Assert clear during a REDUCE cycle, then send 5 = → ready=1 next cycle, answer=5. A strobe during ready=0 is not consumed.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, precedence, evaluator states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package calc_pkg;

  // Operator token codes, shared with the front-end state machine and the VGA buffer.
  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_EQ  = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    FINISH,
    DONE,
    ERROR
  } state_t;

  // Binding strength; 0 for anything that is not an arithmetic operator.
  function automatic logic [1:0] prec(input logic [3:0] op);
    case (op)
      OP_MUL:         prec = 2'd2;
      OP_ADD, OP_SUB: prec = 2'd1;
      default:        prec = 2'd0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/calc_stack.sv
// LIFO stack with push, pop, replace-top (push+pop) and fold (drop two, push one).
// Latency: writes take effect at the next clk edge; top/below/count/full/empty read registers.
// Backpressure: none; push when full and pop when empty are ignored, the owner must check.
// Ports: clk, reset_n (sync, active-low), clear; push, pop, fold, data_in;
//        top (entry at count-1), below (entry at count-2), count, full, empty.
module calc_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     fold,
  input  logic [W-1:0]             data_in,
  output logic [W-1:0]             top,
  output logic [W-1:0]             below,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] TWO   = (AW+1)'(2);
  localparam logic [AW:0] CAP   = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  cnt_m1;
  logic [AW:0]  cnt_m2;
  logic         do_push;
  logic         do_pop;
  logic         do_repl;
  logic         do_fold;

  assign cnt_m1 = count - ONE;
  assign cnt_m2 = count - TWO;

  assign top   = mem[cnt_m1[AW-1:0]];
  assign below = mem[cnt_m2[AW-1:0]];
  assign full  = (count == CAP);
  assign empty = (count == '0);

  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;
  assign do_repl = push && pop && !fold && !empty;
  // Fold: the result of the two top entries lands where the lower one sat.
  assign do_fold = push && pop && fold && (count >= TWO);

  // Storage needs no reset; count alone defines what is live.
  always_ff @(posedge clk) begin
    if (do_fold) begin
      mem[cnt_m2[AW-1:0]] <= data_in;
    end else if (do_repl) begin
      mem[cnt_m1[AW-1:0]] <= data_in;
    end else if (do_push) begin
      mem[count[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + ONE;
    end else if (do_pop || do_fold) begin
      count <= cnt_m1;
    end
  end

endmodule

// File: rtl/rpn_stack_eval.sv
// Infix evaluator with precedence (two-stack shunting-yard) over an operand/operator token stream.
// Latency: operands and non-reducing ops take 1 cycle; a reducing op holds ready low k+1 cycles; '=' gives done n+1 cycles later.
// Backpressure: ready low in REDUCE/FINISH/DONE/ERROR; strobes while ready=0 are ignored, upstream must hold.
// Ports: clk, reset_n (sync, active-low), clear (soft reset); strobe, is_op, token in;
//        ready, answer, done, error out (all registered).
module rpn_stack_eval
  import calc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         strobe,
  input  logic         is_op,
  input  logic [W-1:0] token,
  output logic         ready,
  output logic [W-1:0] answer,
  output logic         done,
  output logic         error
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [3:0]    pend;          // operator waiting for reductions to finish

  logic [W-1:0]  val_top, val_below, val_din;
  logic [CW-1:0] val_cnt;
  logic          val_full, val_empty, val_push, val_pop;

  logic [3:0]    op_top, op_below, op_din;
  logic [CW-1:0] op_cnt;
  logic          op_full, op_empty, op_push, op_pop;

  logic [3:0]    code;
  logic          idle_fire, in_reduce, higher_top, reduce_want, short_ops, do_reduce;
  logic [W-1:0]  alu;

  assign code      = token[3:0];
  assign idle_fire = (state == IDLE) && strobe;
  assign in_reduce = (state == REDUCE);

  // Stacked op binds at least as tightly as the incoming/pending one: reduce it first.
  assign higher_top  = !op_empty && (prec(op_top) >= prec(in_reduce ? pend : code));
  assign reduce_want = (in_reduce && higher_top) || ((state == FINISH) && (op_cnt != '0));
  assign short_ops   = val_empty || (val_cnt == CW'(1));
  assign do_reduce   = reduce_want && !short_ops;

  always_comb begin
    alu = val_top;
    case (op_top)
      OP_ADD:  alu = val_below + val_top;
      OP_SUB:  alu = val_below - val_top;
      OP_MUL:  alu = val_below * val_top;
      default: alu = val_top;
    endcase
  end

  assign val_push = (idle_fire && !is_op && !val_full) || do_reduce;
  assign val_pop  = do_reduce;
  assign val_din  = do_reduce ? alu : token;

  assign op_push = (idle_fire && is_op && is_arith(code) && !higher_top && !op_full)
                 || (in_reduce && !higher_top);
  assign op_pop  = do_reduce;
  assign op_din  = in_reduce ? pend : code;

  calc_stack #(.W(W), .DEPTH(DEPTH)) u_val_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (val_push),
    .pop     (val_pop),
    .fold    (do_reduce),
    .data_in (val_din),
    .top     (val_top),
    .below   (val_below),
    .count   (val_cnt),
    .full    (val_full),
    .empty   (val_empty)
  );

  calc_stack #(.W(4), .DEPTH(DEPTH)) u_op_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (op_push),
    .pop     (op_pop),
    .fold    (1'b0),
    .data_in (op_din),
    .top     (op_top),
    .below   (op_below),
    .count   (op_cnt),
    .full    (op_full),
    .empty   (op_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state  <= IDLE;
      pend   <= '0;
      ready  <= 1'b1;
      answer <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            if (!is_op) begin
              if (val_full) begin
                state <= ERROR; error <= 1'b1; ready <= 1'b0; answer <= '0;
              end
            end else if (code == OP_EQ) begin
              state <= FINISH;
              ready <= 1'b0;
            end else if (!is_arith(code)) begin
              state <= ERROR; error <= 1'b1; ready <= 1'b0; answer <= '0;
            end else if (higher_top) begin
              pend  <= code;
              state <= REDUCE;
              ready <= 1'b0;
            end else if (op_full) begin
              state <= ERROR; error <= 1'b1; ready <= 1'b0; answer <= '0;
            end
          end
        end
        REDUCE: begin
          if (higher_top) begin
            if (short_ops) begin
              state <= ERROR; error <= 1'b1; ready <= 1'b0; answer <= '0;
            end
          end else begin
            // Pending op is pushed this cycle by the stack control above.
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        FINISH: begin
          if (op_cnt != '0) begin
            if (short_ops) begin
              state <= ERROR; error <= 1'b1; ready <= 1'b0; answer <= '0;
            end
          end else if (val_cnt == CW'(1)) begin
            answer <= val_top;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            state <= ERROR; error <= 1'b1; ready <= 1'b0; answer <= '0;
          end
        end
        default: ;  // DONE and ERROR hold until clear/reset
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_eval.sv
module tb_rpn_stack_eval;
  import calc_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset_n, clear, strobe, is_op;
  logic [W-1:0] token;
  logic         ready, done, error;
  logic [W-1:0] answer;

  int checks = 0;
  int errors = 0;

  rpn_stack_eval #(.DEPTH(DEPTH), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .strobe  (strobe),
    .is_op   (is_op),
    .token   (token),
    .ready   (ready),
    .answer  (answer),
    .done    (done),
    .error   (error)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for ready, strobes one token, returns at the negedge after the accepting edge.
  task automatic send(input logic op, input logic [W-1:0] v);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) chk("send_timeout", W'(ready), 1);
    is_op  = op;
    token  = v;
    strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic send_num(input logic [W-1:0] v);
    send(1'b0, v);
  endtask

  task automatic send_op(input logic [3:0] c);
    send(1'b1, {{(W-4){1'b0}}, c});
  endtask

  task automatic kick_clear;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_fin(output int n);
    n = 0;
    while (!done && !error && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Reference: fold all multiplications into terms, then apply +/- left to right.
  function automatic logic [W-1:0] model(input logic [W-1:0] v[$], input logic [3:0] o[$]);
    logic [W-1:0] terms[$];
    logic [3:0]   addops[$];
    logic [W-1:0] t, acc;
    t = v[0];
    for (int i = 0; i < o.size(); i++) begin
      if (o[i] == OP_MUL) t = t * v[i+1];
      else begin
        terms.push_back(t);
        addops.push_back(o[i]);
        t = v[i+1];
      end
    end
    terms.push_back(t);
    acc = terms[0];
    for (int i = 0; i < addops.size(); i++)
      acc = (addops[i] == OP_ADD) ? acc + terms[i+1] : acc - terms[i+1];
    return acc;
  endfunction

  initial begin
    int           n;
    logic [W-1:0] vq[$];
    logic [3:0]   oq[$];
    logic [3:0]   opts[3];
    int           nv;

    opts    = '{OP_ADD, OP_SUB, OP_MUL};
    reset_n = 1'b0;
    clear   = 1'b0;
    strobe  = 1'b0;
    is_op   = 1'b0;
    token   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  W'(ready), 1);
    chk("rst_answer", answer, 0);
    chk("rst_done",   W'(done), 0);
    chk("rst_error",  W'(error), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 2 + 3 * 4 = : no reductions before '=', two ops stacked at '='
    send_num(2);    chk("t1_rdy_2", W'(ready), 1);
    send_op(OP_ADD); chk("t1_rdy_add", W'(ready), 1);
    send_num(3);    chk("t1_rdy_3", W'(ready), 1);
    send_op(OP_MUL); chk("t1_rdy_mul", W'(ready), 1);
    send_num(4);    chk("t1_rdy_4", W'(ready), 1);
    send_op(OP_EQ);
    wait_fin(n);
    chk("t1_latency", n, 3);
    chk("t1_done", W'(done), 1);
    chk("t1_error", W'(error), 0);
    chk("t1_answer", answer, 14);
    // Strobe in DONE must not disturb the held result
    is_op = 1'b0; token = 77; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    chk("t1_hold_answer", answer, 14);
    chk("t1_hold_done", W'(done), 1);
    chk("t1_hold_ready", W'(ready), 0);
    kick_clear;
    chk("clr_answer", answer, 0);
    chk("clr_done", W'(done), 0);
    chk("clr_ready", W'(ready), 1);

    // 2 * 3 + 4 = : '+' forces one reduction, ready low 2 cycles
    send_num(2); send_op(OP_MUL); send_num(3); send_op(OP_ADD);
    wait_ready(n);
    chk("t2_ready_low", n, 2);
    send_num(4); send_op(OP_EQ);
    wait_fin(n);
    chk("t2_latency", n, 2);
    chk("t2_answer", answer, 10);
    kick_clear;

    // 7 - 2 - 1 = with a strobe during ready=0 that must be dropped
    send_num(7); send_op(OP_SUB); send_num(2); send_op(OP_SUB);
    chk("t3_ready_low", W'(ready), 0);
    is_op = 1'b0; token = 99; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    wait_ready(n);
    chk("t3_ready_rest", n, 1);
    send_num(1); send_op(OP_EQ);
    wait_fin(n);
    chk("t3_answer", answer, 4);
    chk("t3_error", W'(error), 0);
    kick_clear;

    // Wrap-around add and truncated multiply
    send_num(32'hFFFF_FFFF); send_op(OP_ADD); send_num(1); send_op(OP_EQ);
    wait_fin(n);
    chk("t4_wrap_answer", answer, 0);
    chk("t4_wrap_done", W'(done), 1);
    kick_clear;
    send_num(32'h1_0000); send_op(OP_MUL); send_num(32'h1_0000); send_op(OP_EQ);
    wait_fin(n);
    chk("t5_mul_answer", answer, 0);
    chk("t5_mul_error", W'(error), 0);
    chk("t5_mul_done", W'(done), 1);
    kick_clear;

    // Operand stack overflow on the ninth push
    for (int i = 0; i < DEPTH; i++) send_num(W'(i + 1));
    chk("t6_rdy_full", W'(ready), 1);
    chk("t6_no_err_yet", W'(error), 0);
    send_num(9);
    chk("t6_error", W'(error), 1);
    chk("t6_answer", answer, 0);
    chk("t6_ready", W'(ready), 0);
    chk("t6_done", W'(done), 0);
    kick_clear;

    // "3 + =" : reduction with one operand
    send_num(3); send_op(OP_ADD); send_op(OP_EQ);
    wait_fin(n);
    chk("t7_error", W'(error), 1);
    chk("t7_done", W'(done), 0);
    chk("t7_answer", answer, 0);
    kick_clear;

    // Unknown operator code
    send_num(6); send_op(4'h5);
    chk("t8_bad_op", W'(error), 1);
    kick_clear;

    // Clear during REDUCE, then 5 =
    send_num(2); send_op(OP_MUL); send_num(3); send_op(OP_ADD);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t9_ready_after_clr", W'(ready), 1);
    chk("t9_error_after_clr", W'(error), 0);
    send_num(5); send_op(OP_EQ);
    wait_fin(n);
    chk("t9_latency", n, 1);
    chk("t9_answer", answer, 5);
    kick_clear;

    // Random well-formed expressions against the reference model
    for (int it = 0; it < 25; it++) begin
      vq.delete();
      oq.delete();
      nv = $urandom_range(1, 6);
      for (int i = 0; i < nv; i++) begin
        vq.push_back(($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 20)));
        if (i > 0) oq.push_back(opts[$urandom_range(0, 2)]);
      end
      send_num(vq[0]);
      for (int i = 0; i < oq.size(); i++) begin
        send_op(oq[i]);
        send_num(vq[i+1]);
      end
      send_op(OP_EQ);
      wait_fin(n);
      chk("rand_done", W'(done), 1);
      chk("rand_error", W'(error), 0);
      chk("rand_answer", answer, model(vq, oq));
      kick_clear;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
